enqueue_agent_v0_2: RTL and testbench

- Parametrised successor of the scheduler enqueue agent. Sits between the P4 pipeline output (sume_meta tuser) and the per-port packet buffers and PIFOs of scheduler_top.
- Per packet: decodes destination ports for NUM_NF_PORTS ports plus CPU, then admits it to non-full queues (unicast-first or full multicast mode) or drops it.
- Per-destination write-enable masks are held for the whole packet and gated per beat. Optional per-reason packet statistics.

---
 rtl/scheduler_pkg.sv | 27 ++
 rtl/enq_port_decode.sv | 46 ++++
 rtl/enqueue_agent_v0_2.sv | 149 ++++++++++++++
 tb/tb_enqueue_agent_v0_2.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scheduler_pkg.sv
// ============================================================================
// scheduler_pkg : shared enqueue-agent FSM encoding and sume_meta field map
// Revision      : v0.2
// ============================================================================
`default_nettype none

package scheduler_pkg;

  localparam int STATES_WIDTH = 2;

  typedef enum logic [STATES_WIDTH-1:0] {
    IDLE    = 2'd0,
    ENQUEUE = 2'd1,
    DROP    = 2'd2
  } enq_state_e;

  localparam int SUME_DST_POS  = 24;
  localparam int SUME_DROP_POS = 32;

  // The CPU queue always sits just above the physical ports.
  function automatic int cpu_queue_idx(input int num_nf_ports);
    return num_nf_ports;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enq_port_decode.sv
// ============================================================================
// enq_port_decode : dst_port decode, queue eligibility and priority select
// Revision        : v0.2
// ============================================================================
`default_nettype none

module enq_port_decode
  import scheduler_pkg::*;
#(
  parameter int NUM_NF_PORTS   = 4,
  parameter int MULTICAST_MODE = 1
) (
  input  logic [2*NUM_NF_PORTS-1:0] dst_i,
  input  logic [NUM_NF_PORTS:0]     almost_full_i,
  input  logic [NUM_NF_PORTS:0]     pifo_full_i,
  output logic [NUM_NF_PORTS:0]     eligible_o,
  output logic [NUM_NF_PORTS:0]     sel_o
);

  localparam int QUEUE_NUM = NUM_NF_PORTS + 1;
  localparam int CPU_IDX   = cpu_queue_idx(NUM_NF_PORTS);

  logic [QUEUE_NUM-1:0]    decoded;
  logic [NUM_NF_PORTS-1:0] nf_bits;
  logic [NUM_NF_PORTS-1:0] cpu_bits;

  // Even dst bits address physical ports, odd bits all map onto the CPU queue.
  for (genvar i = 0; i < NUM_NF_PORTS; i++) begin : g_port
    assign nf_bits[i]  = dst_i[2*i];
    assign cpu_bits[i] = dst_i[2*i+1];
  end

  assign decoded[NUM_NF_PORTS-1:0] = nf_bits;
  assign decoded[CPU_IDX]          = |cpu_bits;

  assign eligible_o = decoded & ~almost_full_i & ~pifo_full_i;

  if (MULTICAST_MODE != 0) begin : g_mcast
    assign sel_o = eligible_o;
  end else begin : g_ucast
    assign sel_o = eligible_o & (~eligible_o + QUEUE_NUM'(1));
  end

endmodule

`default_nettype wire

// File: rtl/enqueue_agent_v0_2.sv
// ============================================================================
// enqueue_agent_v0_2 : admits/drops P4 packets into per-port buffers and PIFOs;
//                      ENQ_AGENT_STATS_EN adds saturating per-reason counters
// Revision           : v0.2
// ============================================================================
`default_nettype none

module enqueue_agent_v0_2
  import scheduler_pkg::*;
#(
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_NF_PORTS         = 4,
  parameter int DST_POS              = SUME_DST_POS,
  parameter int DROP_POS             = SUME_DROP_POS,
  parameter int MULTICAST_MODE       = 1,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic [NUM_NF_PORTS:0]           s_axis_buffer_almost_full,
  input  logic [NUM_NF_PORTS:0]           s_axis_pifo_full,
  output logic [NUM_NF_PORTS:0]           m_axis_ctl_pifo_in_en,
  output logic [NUM_NF_PORTS:0]           m_axis_ctl_buffer_wr_en,
  output logic [CNT_WIDTH-1:0]            stat_enq_pkts,
  output logic [CNT_WIDTH-1:0]            stat_drop_meta,
  output logic [CNT_WIDTH-1:0]            stat_drop_full
);

  localparam int QUEUE_NUM = NUM_NF_PORTS + 1;

  enq_state_e           state_q, state_d;
  logic [QUEUE_NUM-1:0] mask_q, mask_d;
  logic                 first_beat_q, first_beat_d;
  logic [QUEUE_NUM-1:0] eligible;
  logic [QUEUE_NUM-1:0] sel_mask;
  logic                 drop_bit;
  logic                 enq_evt, drop_meta_evt, drop_full_evt;
  logic                 unused_tuser;

  assign drop_bit     = s_axis_tuser[DROP_POS];
  assign unused_tuser = ^s_axis_tuser;

  enq_port_decode #(
    .NUM_NF_PORTS   (NUM_NF_PORTS),
    .MULTICAST_MODE (MULTICAST_MODE)
  ) u_decode (
    .dst_i         (s_axis_tuser[DST_POS +: 2*NUM_NF_PORTS]),
    .almost_full_i (s_axis_buffer_almost_full),
    .pifo_full_i   (s_axis_pifo_full),
    .eligible_o    (eligible),
    .sel_o         (sel_mask)
  );

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      first_beat_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      first_beat_q <= first_beat_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    mask_d                  = mask_q;
    first_beat_d            = first_beat_q;
    s_axis_tready           = 1'b0;
    m_axis_ctl_buffer_wr_en = '0;
    m_axis_ctl_pifo_in_en   = '0;
    enq_evt                 = 1'b0;
    drop_meta_evt           = 1'b0;
    drop_full_evt           = 1'b0;
    case (state_q)
      IDLE: begin
        // Header is held, not accepted, while the admission decision is made.
        if (s_axis_tvalid) begin
          first_beat_d = 1'b1;
          if (drop_bit) begin
            state_d       = DROP;
            drop_meta_evt = 1'b1;
          end else if (eligible == '0) begin
            state_d       = DROP;
            drop_full_evt = 1'b1;
          end else begin
            state_d = ENQUEUE;
            mask_d  = sel_mask;
            enq_evt = 1'b1;
          end
        end
      end
      ENQUEUE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          m_axis_ctl_buffer_wr_en = mask_q;
          if (first_beat_q) m_axis_ctl_pifo_in_en = mask_q;
          first_beat_d = 1'b0;
          if (s_axis_tlast) begin
            state_d      = IDLE;
            first_beat_d = 1'b1;
          end
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ENQ_AGENT_STATS_EN
  logic [CNT_WIDTH-1:0] enq_cnt_q, drop_meta_cnt_q, drop_full_cnt_q;

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      enq_cnt_q       <= '0;
      drop_meta_cnt_q <= '0;
      drop_full_cnt_q <= '0;
    end else begin
      if (enq_evt && !(&enq_cnt_q))
        enq_cnt_q <= enq_cnt_q + CNT_WIDTH'(1);
      if (drop_meta_evt && !(&drop_meta_cnt_q))
        drop_meta_cnt_q <= drop_meta_cnt_q + CNT_WIDTH'(1);
      if (drop_full_evt && !(&drop_full_cnt_q))
        drop_full_cnt_q <= drop_full_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stat_enq_pkts  = enq_cnt_q;
  assign stat_drop_meta = drop_meta_cnt_q;
  assign stat_drop_full = drop_full_cnt_q;
`else
  logic unused_stat_evts;
  assign unused_stat_evts = enq_evt ^ drop_meta_evt ^ drop_full_evt;
  assign stat_enq_pkts    = '0;
  assign stat_drop_meta   = '0;
  assign stat_drop_full   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_enqueue_agent_v0_2.sv
// ============================================================================
// tb_enqueue_agent_v0_2 : directed bench, multicast and unicast instances
// Revision              : v0.2
// ============================================================================
`default_nettype none

module tb_enqueue_agent_v0_2;

  localparam int TW       = 128;
  localparam int NP       = 4;
  localparam int CW       = 2;
  localparam int DST_POS  = 24;
  localparam int DROP_POS = 32;
`ifdef ENQ_AGENT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          tvalid, tlast;
  logic [TW-1:0] tuser;
  logic [NP:0]   almost_full, pifo_full;
  logic          tready1, tready0;
  logic [NP:0]   pifo1, wr1, pifo0, wr0;
  logic [CW-1:0] enq1, meta1, full1, enq0, meta0, full0;

  int n_cmp = 0;
  int n_err = 0;
  int enq_n = 0, meta_n = 0, full_n = 0;
  int wr_cnt;

  always #5 clk = ~clk;

  enqueue_agent_v0_2 #(
    .C_S_AXIS_TUSER_WIDTH(TW), .NUM_NF_PORTS(NP), .DST_POS(DST_POS),
    .DROP_POS(DROP_POS), .MULTICAST_MODE(1), .CNT_WIDTH(CW)
  ) u_dut_mc (
    .axis_aclk(clk), .axis_resetn(rstn), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready1), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .s_axis_buffer_almost_full(almost_full), .s_axis_pifo_full(pifo_full),
    .m_axis_ctl_pifo_in_en(pifo1), .m_axis_ctl_buffer_wr_en(wr1),
    .stat_enq_pkts(enq1), .stat_drop_meta(meta1), .stat_drop_full(full1)
  );

  enqueue_agent_v0_2 #(
    .C_S_AXIS_TUSER_WIDTH(TW), .NUM_NF_PORTS(NP), .DST_POS(DST_POS),
    .DROP_POS(DROP_POS), .MULTICAST_MODE(0), .CNT_WIDTH(CW)
  ) u_dut_uc (
    .axis_aclk(clk), .axis_resetn(rstn), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready0), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .s_axis_buffer_almost_full(almost_full), .s_axis_pifo_full(pifo_full),
    .m_axis_ctl_pifo_in_en(pifo0), .m_axis_ctl_buffer_wr_en(wr0),
    .stat_enq_pkts(enq0), .stat_drop_meta(meta0), .stat_drop_full(full0)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    if (!STATS) return 32'd0;
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  task automatic check_stats(input string tag);
    check_val({tag, "_stat_enq"},  32'(enq1),  exp_cnt(enq_n));
    check_val({tag, "_stat_meta"}, 32'(meta1), exp_cnt(meta_n));
    check_val({tag, "_stat_full"}, 32'(full1), exp_cnt(full_n));
  endtask

  task automatic set_hdr(input logic [7:0] dst, input logic drp);
    tuser = '0;
    tuser[DST_POS +: 8] = dst;
    tuser[DROP_POS]     = drp;
  endtask

  // Full inputs go all-ones after the header to prove the latched mask holds.
  task automatic run_pkt(input string tag, input logic [7:0] dst, input logic drp,
                         input logic [NP:0] af, input logic [NP:0] pf, input int nb,
                         input logic [NP:0] m1, input logic [NP:0] m0);
    set_hdr(dst, drp);
    almost_full = af;
    pifo_full   = pf;
    tvalid      = 1'b1;
    tlast       = 1'b0;
    #1;
    check_val({tag, "_hdr_rdy"}, 32'(tready1), 32'd0);
    check_val({tag, "_hdr_wr"},  32'(wr1),     32'd0);
    check_val({tag, "_hdr_pifo"}, 32'(pifo1),  32'd0);
    @(posedge clk); #1;
    almost_full = '1;
    pifo_full   = '1;
    for (int b = 0; b < nb; b++) begin
      tlast = (b == nb - 1);
      #1;
      check_val({tag, "_rdy"},   32'(tready1), 32'd1);
      check_val({tag, "_wr1"},   32'(wr1),     32'(m1));
      check_val({tag, "_pifo1"}, 32'(pifo1),   (b == 0) ? 32'(m1) : 32'd0);
      check_val({tag, "_wr0"},   32'(wr0),     32'(m0));
      check_val({tag, "_pifo0"}, 32'(pifo0),   (b == 0) ? 32'(m0) : 32'd0);
      @(posedge clk); #1;
    end
    tvalid      = 1'b0;
    tlast       = 1'b0;
    almost_full = '0;
    pifo_full   = '0;
    #1;
    check_val({tag, "_end_rdy"}, 32'(tready1), 32'd0);
  endtask

  initial begin
    rstn        = 1'b0;
    tvalid      = 1'b0;
    tlast       = 1'b0;
    tuser       = '0;
    almost_full = '0;
    pifo_full   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rdy",  32'(tready1), 32'd0);
    check_val("rst_wr",   32'(wr1),     32'd0);
    check_val("rst_pifo", 32'(pifo1),   32'd0);
    check_stats("rst");
    rstn = 1'b1;
    @(posedge clk); #1;

    run_pkt("uni_p1", 8'h04, 1'b0, 5'b00000, 5'b00000, 3, 5'b00010, 5'b00010);
    enq_n++;
    check_stats("uni_p1");

    run_pkt("mc55", 8'h55, 1'b0, 5'b00010, 5'b00000, 2, 5'b01101, 5'b00001);
    enq_n++;
    check_stats("mc55");

    run_pkt("drop_meta", 8'h01, 1'b1, 5'b00000, 5'b00000, 2, 5'b00000, 5'b00000);
    meta_n++;
    check_stats("drop_meta");

    run_pkt("drop_full", 8'h01, 1'b0, 5'b00000, 5'b00001, 1, 5'b00000, 5'b00000);
    full_n++;
    check_stats("drop_full");

    run_pkt("drop_prio", 8'h01, 1'b1, 5'b00000, 5'b00001, 1, 5'b00000, 5'b00000);
    meta_n++;
    check_stats("drop_prio");

    run_pkt("cpu_single", 8'h80, 1'b0, 5'b00000, 5'b00000, 1, 5'b10000, 5'b10000);
    enq_n++;
    check_stats("cpu_single");

    // tvalid gap mid-packet: writes only on valid beats
    set_hdr(8'h10, 1'b0);
    tvalid = 1'b1;
    tlast  = 1'b0;
    wr_cnt = 0;
    #1;
    check_val("gap_hdr_rdy", 32'(tready1), 32'd0);
    @(posedge clk); #1;
    #1;
    check_val("gap_b1_wr",   32'(wr1),   32'b00100);
    check_val("gap_b1_pifo", 32'(pifo1), 32'b00100);
    if (wr1 != '0) wr_cnt++;
    @(posedge clk); #1;
    tvalid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      #1;
      check_val("gap_idle_wr",   32'(wr1),     32'd0);
      check_val("gap_idle_pifo", 32'(pifo1),   32'd0);
      check_val("gap_idle_rdy",  32'(tready1), 32'd1);
      if (wr1 != '0) wr_cnt++;
      @(posedge clk); #1;
    end
    tvalid = 1'b1;
    tlast  = 1'b1;
    #1;
    check_val("gap_last_wr",   32'(wr1),   32'b00100);
    check_val("gap_last_pifo", 32'(pifo1), 32'd0);
    if (wr1 != '0) wr_cnt++;
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    check_val("gap_wr_cycles", 32'(wr_cnt), 32'd2);
    enq_n++;
    check_stats("gap_sat_enq");

    for (int k = 0; k < 2; k++) begin
      run_pkt("drop_more", 8'h04, 1'b1, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000);
      meta_n++;
    end
    check_stats("sat_meta");
    check_val("uc_stat_enq", 32'(enq0), exp_cnt(enq_n));

    // reset asserted during the second data beat
    set_hdr(8'h04, 1'b0);
    tvalid = 1'b1;
    tlast  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    #1;
    enq_n  = 0;
    meta_n = 0;
    full_n = 0;
    check_val("midrst_rdy",  32'(tready1), 32'd0);
    check_val("midrst_wr",   32'(wr1),     32'd0);
    check_val("midrst_pifo", 32'(pifo1),   32'd0);
    check_stats("midrst");
    rstn = 1'b1;

    run_pkt("post_rst", 8'h04, 1'b0, 5'b00000, 5'b00000, 1, 5'b00010, 5'b00010);
    enq_n++;
    check_stats("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
